// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one inverse round per clock over NR rounds,
// fed from an external zero-latency round-key store, valid/ready on both sides.

module addRoundKey (
    input  logic [0:127] st,
    input  logic [0:127] rk,
    output logic [0:127] res
);
    assign res = st ^ rk;
endmodule

module inv_mixcol_col (
    input  logic [0:31] col,
    output logic [0:31] res
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0] x2, x4, x8;
        assign a[i]  = col[8*i +: 8];
        assign x2    = xtime(a[i]);
        assign x4    = xtime(x2);
        assign x8    = xtime(x4);
        assign m9[i] = x8 ^ a[i];
        assign mb[i] = x8 ^ x2 ^ a[i];
        assign md[i] = x8 ^ x4 ^ a[i];
        assign me[i] = x8 ^ x4 ^ x2;
    end

    // Row i of the circulant {0e,0b,0d,09} matrix, rotated right by i.
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign res[8*i +: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
endmodule

module inverse_mixcol (
    input  logic [0:127] st,
    output logic [0:127] res
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mixcol_col u_col (
            .col (st[32*c +: 32]),
            .res (res[32*c +: 32])
        );
    end
endmodule

module inv_shift_rows (
    input  logic [0:127] st,
    output logic [0:127] res
);
    // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign res[8*(r+4*c) +: 8] = st[8*(r+4*((c-r+4)%4)) +: 8];
        end
    end
endmodule

module inv_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Undo the affine map, then invert in GF(2^8) as b^254 (0 maps to 0).
    logic [7:0] b, b2, b3, b6, b12, b15, b30, b60, b120, b240;
    assign b    = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    assign b2   = gmul(b, b);
    assign b3   = gmul(b2, b);
    assign b6   = gmul(b3, b3);
    assign b12  = gmul(b6, b6);
    assign b15  = gmul(b12, b3);
    assign b30  = gmul(b15, b15);
    assign b60  = gmul(b30, b30);
    assign b120 = gmul(b60, b60);
    assign b240 = gmul(b120, b120);
    assign dout = gmul(gmul(b240, b12), b2);
endmodule

module inv_substitution #(
    parameter int NUM_LANES = 16
) (
    input  logic [0:8*NUM_LANES-1] st,
    output logic [0:8*NUM_LANES-1] res
);
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        inv_sbox_lane u_lane (
            .din  (st[8*i +: 8]),
            .dout (res[8*i +: 8])
        );
    end
endmodule

module aes_inv_round_engine #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] NR_IDX  = 4'(NR);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_inv_round_engine: NR must be 10, 12 or 14");
    end

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [0:127] st;
    logic [0:127] ark_in, ark_out, mix_out, pre_shift, shr_out, sub_out;

    // The first round takes the ciphertext directly and has no InvMixColumns.
    assign ark_in    = (state == S_IDLE) ? in_data : st;
    assign pre_shift = (state == S_IDLE) ? ark_out : mix_out;

    addRoundKey      u_ark (.st(ark_in),    .rk(rk_data), .res(ark_out));
    inverse_mixcol   u_imc (.st(ark_out),   .res(mix_out));
    inv_shift_rows   u_isr (.st(pre_shift), .res(shr_out));
    inv_substitution u_isb (.st(shr_out),   .res(sub_out));

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_comb begin
        rk_idx = 4'd0;
        case (state)
            S_IDLE:  rk_idx = NR_IDX;
            S_ROUND: rk_idx = cnt;
            default: rk_idx = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            st        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st    <= sub_out;
                        cnt   <= NR_IDX - 4'd1;
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st <= sub_out;
                    if (cnt == 4'd1) state <= S_FINAL;
                    else             cnt   <= cnt - 4'd1;
                end
                S_FINAL: begin
                    out_data  <= ark_out;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: one engine per key size, FIPS-order AES
// decryption model, per-cycle checking of every output against that model.

module tb_aes_inv_round_engine;
    localparam int NI = 3;
    localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT [NI] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089
    };
    localparam logic [0:127] RK10_LAST = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk, rst_n;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic         busy      [NI];
    logic [0:127] in_data   [NI];
    logic [0:127] rk_data   [NI];
    logic [0:127] out_data  [NI];
    logic [3:0]   rk_idx    [NI];

    logic [0:127] rks [NI][15];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];

    int n_chk = 0, n_fail = 0, n_tmo = 0, n_tmo_seen = 0;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        aes_inv_round_engine #(.NR(10 + 2*g)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .rk_idx    (rk_idx[g]),
            .rk_data   (rk_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
        assign rk_data[g] = rks[g][rk_idx[g]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference AES (FIPS-197 order) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic key_expand(input int g);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nr, nk;
        nr   = 10 + 2*g;
        nk   = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = KEY[32*i +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rks[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] m_inv_shift(input logic [0:127] v);
        logic [0:127] o;
        logic [7:0]   t;
        o = v;
        for (int r = 1; r < 4; r++)
            for (int k = 0; k < r; k++) begin
                t = o[8*(r+12) +: 8];
                for (int c = 3; c > 0; c--) o[8*(r+4*c) +: 8] = o[8*(r+4*(c-1)) +: 8];
                o[8*r +: 8] = t;
            end
        return o;
    endfunction

    function automatic logic [0:127] m_inv_sub(input logic [0:127] v);
        logic [0:127] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = isbox[v[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] m_inv_mix(input logic [0:127] v);
        logic [0:127] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], v[8*(k+4*c) +: 8]);
                o[8*(r+4*c) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [0:127] decrypt(input logic [0:127] ct, input int g);
        logic [0:127] s;
        int nr;
        nr = 10 + 2*g;
        s  = ct ^ rks[g][nr];
        for (int r = nr - 1; r >= 1; r--)
            s = m_inv_mix(m_inv_sub(m_inv_shift(s)) ^ rks[g][r]);
        return m_inv_sub(m_inv_shift(s)) ^ rks[g][0];
    endfunction

    // ---------------- compare process ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic         m_busy [NI];
    int           m_age  [NI];
    logic [0:127] m_exp  [NI];
    logic [0:127] m_last [NI];

    initial begin
        int         nr;
        logic       ev;
        logic [3:0] erk;
        string      tag;
        for (int g = 0; g < NI; g++) begin
            m_busy[g] = 1'b0; m_age[g] = 0; m_exp[g] = '0; m_last[g] = '0;
        end
        @(negedge clk);
        chk("model_rk10_last", rks[0][10], RK10_LAST);
        for (int g = 0; g < NI; g++)
            chk($sformatf("model_kat_nr%0d", 10 + 2*g), decrypt(CT[g], g), PT);
        forever begin
            if (n_tmo != n_tmo_seen) begin
                chk("wait_bound", 128'(n_tmo), 128'(n_tmo_seen));
                n_tmo_seen = n_tmo;
            end
            for (int g = 0; g < NI; g++) begin
                nr  = 10 + 2*g;
                tag = $sformatf("nr%0d", nr);
                if (!rst_n) begin
                    m_busy[g] = 1'b0; m_age[g] = 0; m_last[g] = '0;
                    chk({"rst_out_valid_", tag}, 128'(out_valid[g]), 128'(0));
                    chk({"rst_busy_", tag},      128'(busy[g]),      128'(0));
                    chk({"rst_in_ready_", tag},  128'(in_ready[g]),  128'(1));
                    chk({"rst_rk_idx_", tag},    128'(rk_idx[g]),    128'(nr));
                    chk({"rst_out_data_", tag},  out_data[g],        128'(0));
                end else begin
                    ev  = m_busy[g] && (m_age[g] >= nr + 1);
                    erk = !m_busy[g] ? 4'(nr) : (m_age[g] < nr ? 4'(nr - m_age[g]) : 4'd0);
                    chk({"in_ready_", tag},  128'(in_ready[g]),  128'(!m_busy[g]));
                    chk({"busy_", tag},      128'(busy[g]),      128'(m_busy[g]));
                    chk({"rk_idx_", tag},    128'(rk_idx[g]),    128'(erk));
                    chk({"out_valid_", tag}, 128'(out_valid[g]), 128'(ev));
                    chk({"out_data_", tag},  out_data[g],        ev ? m_exp[g] : m_last[g]);
                    if (!m_busy[g]) begin
                        if (in_valid[g]) begin
                            m_busy[g] = 1'b1;
                            m_age[g]  = 1;
                            m_exp[g]  = decrypt(in_data[g], g);
                        end
                    end else if (ev && out_ready[g]) begin
                        m_busy[g] = 1'b0;
                        m_last[g] = m_exp[g];
                    end else if (m_age[g] < 1000) begin
                        m_age[g]++;
                    end
                end
            end
            @(negedge clk);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [0:127] d, input bit hold);
        int n;
        in_data[g]  = d;
        in_valid[g] = 1'b1;
        n = 0;
        while (!in_ready[g] && n < 100) begin tick(); n++; end
        if (!in_ready[g]) n_tmo++;
        tick();
        if (!hold) in_valid[g] = 1'b0;
    endtask

    task automatic wait_out(input int g);
        int n;
        n = 0;
        while (!(out_valid[g] && out_ready[g]) && n < 100) begin tick(); n++; end
        if (!(out_valid[g] && out_ready[g])) n_tmo++;
        tick();
    endtask

    task automatic wait_valid(input int g);
        int n;
        n = 0;
        while (!out_valid[g] && n < 100) begin tick(); n++; end
        if (!out_valid[g]) n_tmo++;
    endtask

    task automatic wait_rk(input int g, input logic [3:0] v);
        int n;
        n = 0;
        while (rk_idx[g] != v && n < 50) begin tick(); n++; end
        if (rk_idx[g] != v) n_tmo++;
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [0:127] d;
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) begin
            in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
        end
        build_tables();
        for (int g = 0; g < NI; g++) key_expand(g);
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Known-answer blocks for each key size.
        for (int g = 0; g < NI; g++) begin
            out_ready[g] = 1'b1;
            send(g, CT[g], 1'b0);
            wait_out(g);
            tick();
        end

        // Backpressure: output held, new block waits, then goes straight in.
        out_ready[0] = 1'b0;
        send(0, CT[0], 1'b0);
        wait_valid(0);
        d = rnd128();
        in_data[0]  = d;
        in_valid[0] = 1'b1;
        repeat (20) tick();
        out_ready[0] = 1'b1;
        send(0, d, 1'b0);
        wait_out(0);

        // Streaming with in_valid held high.
        for (int i = 0; i < 8; i++) send(0, rnd128(), 1'b1);
        in_valid[0] = 1'b0;
        wait_out(0);
        tick();

        // Reset in the middle of a block.
        send(0, rnd128(), 1'b0);
        wait_rk(0, 4'd5);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        send(0, CT[0], 1'b0);
        wait_out(0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
